// File: rtl/uart_echo_fifo_if.sv
// Handshake bundle for uart_echo_fifo: receive strobe in, transmit strobe/done pair, status out.
// The master side (receiver + transmitter glue) drives rx/tx_done; the FIFO is the slave.
interface uart_echo_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 9
);
  logic                  rx_dv;
  logic [DATA_W-1:0]     rx_byte;
  logic                  tx_dv;
  logic [DATA_W-1:0]     tx_byte;
  logic                  tx_done;
  logic [DEPTH_LOG2:0]   count;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic [4:0]            level_led;

  modport master (
    output rx_dv, rx_byte, tx_done,
    input  tx_dv, tx_byte, count, empty, full, overflow, level_led
  );

  modport slave (
    input  rx_dv, rx_byte, tx_done,
    output tx_dv, tx_byte, count, empty, full, overflow, level_led
  );
endinterface

// File: rtl/uart_echo_fifo.sv
// Elastic byte FIFO between uart_rx and uart_tx2: buffers rx strobes, replays them one per tx_done.
// Optional FIFO_LEVEL_LEDS_EN drives a saturating 5-bit level display on level_led.
module uart_echo_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic            ICE_CLK,
  input  logic            RST_N,
  uart_echo_fifo_if.slave bus
);
  localparam int               PTR_W = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, READ, WAIT} state_e;

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  logic [DATA_W-1:0] ram_dout_q;
  logic [DATA_W-1:0] tx_byte_q;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  count_q, count_d;
  logic              empty_q, full_q, overflow_q, tx_dv_q;
  logic              wr_en, rd_en;
  state_e            state_q;

  // Status is derived from the next pointers so count/empty/full are registered yet never stale.
  always_comb begin
    wr_en    = bus.rx_dv && !full_q;
    rd_en    = (state_q == READ);
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
    count_d  = wr_ptr_d - rd_ptr_d;
  end

  // NOTE: the storage array has no reset so it maps onto block RAM; cleared pointers make old contents unreachable.
  always_ff @(posedge ICE_CLK) begin
    if (wr_en) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= bus.rx_byte;
    ram_dout_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
  end

  // NOTE: reset is sampled on the clock edge, so it is tested inside the block and kept out of the sensitivity list.
  always_ff @(posedge ICE_CLK) begin
    if (!RST_N) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == DEPTH);
      overflow_q <= overflow_q | (bus.rx_dv & full_q);
    end
  end

  // IDLE presents rd_ptr to the RAM; READ consumes the 1-cycle RAM latency and launches the byte.
  always_ff @(posedge ICE_CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
    end else begin
      tx_dv_q <= 1'b0;
      unique case (state_q)
        IDLE: if (!empty_q) state_q <= READ;
        READ: begin
          tx_byte_q <= ram_dout_q;
          tx_dv_q   <= 1'b1;
          state_q   <= WAIT;
        end
        WAIT: if (bus.tx_done) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_dv    = tx_dv_q;
  assign bus.tx_byte  = tx_byte_q;
  assign bus.count    = count_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.overflow = overflow_q;

`ifdef FIFO_LEVEL_LEDS_EN
  logic [4:0] level_led_q;

  always_ff @(posedge ICE_CLK) begin
    if (!RST_N) level_led_q <= '0;
    else        level_led_q <= (count_q > PTR_W'(31)) ? 5'h1F : count_q[4:0];
  end

  assign bus.level_led = level_led_q;
`else
  assign bus.level_led = 5'b0;
`endif
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Self-checking bench for uart_echo_fifo: cycle table for reset/latency, then scoreboarded
// burst, fill/overflow, wrap, randomized and reset-during-WAIT sequences.
module tb_uart_echo_fifo;
  localparam int DATA_W     = 8;
  localparam int DEPTH_LOG2 = 9;
  localparam int DEPTH      = 512;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_echo_fifo_if #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  uart_echo_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .ICE_CLK (clk),
    .RST_N   (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: bytes accepted but not yet launched, in order.
  logic [7:0] exp_q[$];
  bit         model_ovf;
  bit         awaiting_done;
  bit         resp_en;
  int         done_delay;
  int         done_timer;
  int         sent_cnt;
  int         last_count;
  int         peak_dut;

  typedef struct {
    bit         rst_n;
    bit         rx_dv;
    logic [7:0] rx_byte;
    bit         tx_done;
    bit         e_tx_dv;
    logic [7:0] e_tx_byte;
    int         e_count;
    bit         e_empty;
  } vec_t;

  vec_t vt[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] led_of(input int n);
    return (n > 31) ? 5'h1F : n[4:0];
  endfunction

  function automatic vec_t mk(bit r, bit dv, logic [7:0] b, bit d, bit etv, logic [7:0] etb,
                              int ec, bit ee);
    vec_t v;
    v.rst_n = r; v.rx_dv = dv; v.rx_byte = b; v.tx_done = d;
    v.e_tx_dv = etv; v.e_tx_byte = etb; v.e_count = ec; v.e_empty = ee;
    return v;
  endfunction

  // One clock edge with scoreboard, status checks and the transmitter stand-in.
  task automatic tick();
    @(posedge clk); #1;
    if (bus.tx_dv) begin
      sent_cnt++;
      check("tx_while_busy", 32'(awaiting_done), 32'd0);
      if (exp_q.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
      else                   check("tx_byte", 32'(bus.tx_byte), 32'(exp_q.pop_front()));
      awaiting_done = 1'b1;
      if (resp_en) done_timer = done_delay;
    end
    check("count",    32'(bus.count),    32'(exp_q.size()));
    check("empty",    32'(bus.empty),    32'(exp_q.size() == 0));
    check("full",     32'(bus.full),     32'(exp_q.size() == DEPTH));
    check("overflow", 32'(bus.overflow), 32'(model_ovf));
`ifdef FIFO_LEVEL_LEDS_EN
    check("level_led", 32'(bus.level_led), 32'(rst_n ? led_of(last_count) : 5'd0));
`else
    check("level_led", 32'(bus.level_led), 32'd0);
`endif
    if (int'(bus.count) > peak_dut) peak_dut = int'(bus.count);
    last_count  = exp_q.size();
    bus.tx_done = 1'b0;
    if (done_timer > 0) begin
      done_timer--;
      if (done_timer == 0) begin
        bus.tx_done   = 1'b1;
        awaiting_done = 1'b0;
      end
    end
  endtask

  task automatic send(input bit v, input logic [7:0] b);
    bus.rx_dv   = v;
    bus.rx_byte = b;
    if (v) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else                      model_ovf = 1'b1;
    end
    tick();
    bus.rx_dv = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    exp_q.delete();
    model_ovf     = 1'b0;
    awaiting_done = 1'b0;
    done_timer    = 0;
    last_count    = 0;
    bus.tx_done   = 1'b0;
    bus.rx_dv     = 1'b0;
    repeat (cycles) tick();
    rst_n    = 1'b1;
    sent_cnt = 0;
    peak_dut = 0;
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || awaiting_done) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drain_in_time"}, 32'(n < budget), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    bus.rx_dv = 1'b0; bus.rx_byte = '0; bus.tx_done = 1'b0;
    resp_en = 1'b0; done_delay = 1; done_timer = 0; sent_cnt = 0;
    awaiting_done = 1'b0; model_ovf = 1'b0; last_count = 0; peak_dut = 0;

    // Reset with rx strobes, then three single bytes with exact edge timing.
    vt[0]  = mk(0, 1, 8'hAA, 0, 0, 8'h00, 0, 1);
    vt[1]  = mk(0, 1, 8'h55, 1, 0, 8'h00, 0, 1);
    vt[2]  = mk(0, 1, 8'h0F, 0, 0, 8'h00, 0, 1);
    vt[3]  = mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 1);
    vt[4]  = mk(1, 1, 8'h41, 0, 0, 8'h00, 1, 0);
    vt[5]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    vt[6]  = mk(1, 0, 8'h00, 0, 1, 8'h41, 0, 1);
    vt[7]  = mk(1, 0, 8'h00, 0, 0, 8'h41, 0, 1);
    vt[8]  = mk(1, 0, 8'h00, 1, 0, 8'h41, 0, 1);
    vt[9]  = mk(1, 1, 8'h42, 0, 0, 8'h41, 1, 0);
    vt[10] = mk(1, 0, 8'h00, 0, 0, 8'h41, 1, 0);
    vt[11] = mk(1, 0, 8'h00, 0, 1, 8'h42, 0, 1);
    vt[12] = mk(1, 1, 8'h43, 1, 0, 8'h42, 1, 0);
    vt[13] = mk(1, 0, 8'h00, 0, 0, 8'h42, 1, 0);
    vt[14] = mk(1, 0, 8'h00, 0, 1, 8'h43, 0, 1);
    vt[15] = mk(1, 0, 8'h00, 0, 0, 8'h43, 0, 1);

    for (int i = 0; i < 16; i++) begin
      rst_n       = vt[i].rst_n;
      bus.rx_dv   = vt[i].rx_dv;
      bus.rx_byte = vt[i].rx_byte;
      bus.tx_done = vt[i].tx_done;
      @(posedge clk); #1;
      check($sformatf("v%0d_tx_dv", i),   32'(bus.tx_dv),    32'(vt[i].e_tx_dv));
      check($sformatf("v%0d_tx_byte", i), 32'(bus.tx_byte),  32'(vt[i].e_tx_byte));
      check($sformatf("v%0d_count", i),   32'(bus.count),    32'(vt[i].e_count));
      check($sformatf("v%0d_empty", i),   32'(bus.empty),    32'(vt[i].e_empty));
      check($sformatf("v%0d_full", i),    32'(bus.full),     32'd0);
      check($sformatf("v%0d_overflow", i), 32'(bus.overflow), 32'd0);
`ifdef FIFO_LEVEL_LEDS_EN
      check($sformatf("v%0d_level_led", i), 32'(bus.level_led),
            32'((vt[i].rst_n && i > 0) ? led_of(vt[i-1].e_count) : 5'd0));
`else
      check($sformatf("v%0d_level_led", i), 32'(bus.level_led), 32'd0);
`endif
    end
    bus.rx_dv = 1'b0; bus.tx_done = 1'b0;

    // Burst of ten back-to-back bytes, transmitter busy for 20 cycles per byte.
    do_reset(2);
    resp_en = 1'b1; done_delay = 20;
    for (int i = 0; i < 10; i++) send(1'b1, 8'(8'h30 + i));
    drain(1000, "burst");
    check("burst_sent", 32'(sent_cnt), 32'd10);
    check("burst_peak", 32'(peak_dut), 32'd9);
    check("burst_empty_end", 32'(bus.empty), 32'd1);

    // Fill with tx_done withheld, then overrun by one.
    do_reset(2);
    resp_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(1'b1, 8'(i * 7 + 3));
    tick();
    check("fill_count_511", 32'(bus.count), 32'd511);
    check("fill_not_full", 32'(bus.full), 32'd0);
    check("fill_one_sent", 32'(sent_cnt), 32'd1);
    send(1'b1, 8'hEE);
    check("fill_count_512", 32'(bus.count), 32'd512);
    check("fill_full", 32'(bus.full), 32'd1);
    send(1'b1, 8'hDD);
    check("ovf_set", 32'(bus.overflow), 32'd1);
    check("ovf_count_512", 32'(bus.count), 32'd512);
    tick();
`ifdef FIFO_LEVEL_LEDS_EN
    check("fill_level_led", 32'(bus.level_led), 32'h1F);
`endif
    resp_en = 1'b1; done_delay = 1; done_timer = 1;
    drain(10000, "fill");
    check("fill_sent_all", 32'(sent_cnt), 32'd513);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Pointer wrap: 1500 bytes with the transmitter faster than the receiver.
    do_reset(2);
    resp_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      done_delay = int'($urandom_range(1, 3));
      send(1'b1, 8'(i % 256));
      repeat ($urandom_range(5, 7)) tick();
    end
    drain(1000, "wrap");
    check("wrap_sent", 32'(sent_cnt), 32'd1500);
    check("wrap_no_ovf", 32'(bus.overflow), 32'd0);

    // Random traffic with a slow transmitter, driving the buffer into overflow.
    do_reset(2);
    resp_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      done_delay = int'($urandom_range(1, 30));
      send(1'($urandom_range(0, 1)), 8'($urandom));
    end
    done_delay = 1;
    drain(5000, "rand");
    check("rand_ovf_model", 32'(bus.overflow), 32'(model_ovf));
    check("rand_empty_end", 32'(bus.empty), 32'd1);

    // Reset during WAIT with five queued bytes, then a spurious tx_done.
    do_reset(2);
    resp_en = 1'b0;
    for (int i = 0; i < 6; i++) send(1'b1, 8'(8'hA0 + i));
    repeat (3) tick();
    check("wait_queued_5", 32'(bus.count), 32'd5);
    check("wait_first_sent", 32'(sent_cnt), 32'd1);
    do_reset(1);
    bus.tx_done = 1'b1;
    tick();
    repeat (10) tick();
    check("rst_no_resend", 32'(sent_cnt), 32'd0);
    check("rst_count_0", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
